free_reg_list: RTL and testbench

- Circular FIFO of free physical register tags in the renaming front end.
- Dispatch pops one tag per register-writing instruction.
- ROB commit pushes back the Rd physical tag that the committing instruction displaced.
- Publishes its head pointer to the checkpoint table, which snapshots it per branch. On a CDB flush the checkpoint table returns the snapshot, and the head rewinds to it, reclaiming every tag allocated on the wrong path.

---
 rtl/free_reg_list.sv | 77 +++++++
 tb/tb_free_reg_list.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/free_reg_list.sv
// Circular free list of physical register tags: dispatch pops at head, ROB
// commit pushes freed tags at tail, and a CDB flush rewinds head to a checkpoint.
module free_reg_list #(
  parameter int DEPTH     = 16,
  parameter int PTR_W     = 5,
  parameter int PR_W      = 6,
  parameter int INIT_BASE = 32
) (
  input  logic             Clk,
  input  logic             Resetb,
  input  logic             Dis_FrlRead,
  output logic [PR_W-1:0]  Frl_RdPhyAddr,
  output logic             Frl_Empty,
  output logic [PTR_W-1:0] Frl_HeadPtr,
  input  logic             Rob_Commit,
  input  logic             Rob_CommitRegWrite,
  input  logic [PR_W-1:0]  Rob_CommitPrePhyAddr,
  input  logic             Cdb_Flush,
  input  logic [PTR_W-1:0] Cfc_FrlHeadPtr,
  output logic [PTR_W-1:0] Frl_Count,
  output logic             Frl_Overflow
);

  localparam int IDX_W = PTR_W - 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic             ovf_q, ovf_d;
  logic [PR_W-1:0]  mem_q [DEPTH];

  logic empty, full, push_req, push_en;

  assign empty = (head_q == tail_q);
  assign full  = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &&
                 (head_q[PTR_W-1] != tail_q[PTR_W-1]);

  assign push_req = Rob_Commit && Rob_CommitRegWrite;
  assign push_en  = push_req && !full;

  // Flush takes priority over a same-cycle pop; push is never blocked by flush.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    ovf_d  = ovf_q;
    if (Cdb_Flush)
      head_d = Cfc_FrlHeadPtr;
    else if (Dis_FrlRead && !empty)
      head_d = head_q + 1'b1;
    if (push_en)
      tail_d = tail_q + 1'b1;
    if (push_req && full)
      ovf_d = 1'b1;
  end

  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      head_q <= '0;
      tail_q <= PTR_W'(DEPTH);
      ovf_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++)
        mem_q[i] <= PR_W'(INIT_BASE + i);
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      ovf_q  <= ovf_d;
      if (push_en)
        mem_q[tail_q[IDX_W-1:0]] <= Rob_CommitPrePhyAddr;
    end
  end

  assign Frl_RdPhyAddr = mem_q[head_q[IDX_W-1:0]];
  assign Frl_Empty     = empty;
  assign Frl_HeadPtr   = head_q;
  assign Frl_Count     = tail_q - head_q;
  assign Frl_Overflow  = ovf_q;

endmodule

// File: tb/tb_free_reg_list.sv
// Bench for free_reg_list: directed scenarios plus random traffic against a
// model that tracks every tag ever queued by absolute sequence number.
module tb_free_reg_list;

  localparam int DEPTH = 16;
  localparam int PTR_W = 5;
  localparam int PR_W  = 6;
  localparam int BASE  = 32;

  logic             Clk = 1'b0;
  logic             Resetb = 1'b1;
  logic             Dis_FrlRead = 1'b0;
  logic [PR_W-1:0]  Frl_RdPhyAddr;
  logic             Frl_Empty;
  logic [PTR_W-1:0] Frl_HeadPtr;
  logic             Rob_Commit = 1'b0;
  logic             Rob_CommitRegWrite = 1'b0;
  logic [PR_W-1:0]  Rob_CommitPrePhyAddr = '0;
  logic             Cdb_Flush = 1'b0;
  logic [PTR_W-1:0] Cfc_FrlHeadPtr = '0;
  logic [PTR_W-1:0] Frl_Count;
  logic             Frl_Overflow;

  int errors = 0;
  int checks = 0;

  // Reference: absolute head/tail counters and history of tags by position.
  int m_head, m_tail;
  bit m_ovf;
  int m_ent [int];

  free_reg_list #(.DEPTH(DEPTH), .PTR_W(PTR_W), .PR_W(PR_W), .INIT_BASE(BASE)) dut (
    .Clk(Clk), .Resetb(Resetb), .Dis_FrlRead(Dis_FrlRead),
    .Frl_RdPhyAddr(Frl_RdPhyAddr), .Frl_Empty(Frl_Empty), .Frl_HeadPtr(Frl_HeadPtr),
    .Rob_Commit(Rob_Commit), .Rob_CommitRegWrite(Rob_CommitRegWrite),
    .Rob_CommitPrePhyAddr(Rob_CommitPrePhyAddr), .Cdb_Flush(Cdb_Flush),
    .Cfc_FrlHeadPtr(Cfc_FrlHeadPtr), .Frl_Count(Frl_Count), .Frl_Overflow(Frl_Overflow)
  );

  always #5 Clk = ~Clk;

  function automatic int m_count();
    return m_tail - m_head;
  endfunction

  task automatic model_reset();
    m_head = 0;
    m_tail = DEPTH;
    m_ovf  = 1'b0;
    m_ent.delete();
    for (int i = 0; i < DEPTH; i++) m_ent[i] = BASE + i;
  endtask

  task automatic do_reset();
    Dis_FrlRead = 0; Rob_Commit = 0; Rob_CommitRegWrite = 0; Cdb_Flush = 0;
    Resetb = 1'b0;
    #2;
    model_reset();
    Resetb = 1'b1;
    #1;
  endtask

  // Drive one cycle of inputs, wait for the edge, then advance the model.
  task automatic cycle(input bit pop, input bit cm, input bit rw, input int tag,
                       input bit fl, input int cfc);
    int cnt;
    Dis_FrlRead = pop; Rob_Commit = cm; Rob_CommitRegWrite = rw;
    Rob_CommitPrePhyAddr = PR_W'(tag); Cdb_Flush = fl; Cfc_FrlHeadPtr = PTR_W'(cfc);
    @(posedge Clk);
    cnt = m_count();
    if (cm && rw) begin
      if (cnt == DEPTH) m_ovf = 1'b1;
      else begin m_ent[m_tail] = tag; m_tail++; end
    end
    if (fl) m_head = m_head - (((m_head % 32) - cfc + 32) % 32);
    else if (pop && cnt > 0) m_head++;
    #1;
    Dis_FrlRead = 0; Rob_Commit = 0; Rob_CommitRegWrite = 0; Cdb_Flush = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (Frl_Count !== 5'd16) begin errors++; $display("FAIL reset_count got=%0d exp=16", Frl_Count); end
    if (Frl_Empty !== 1'b0) begin errors++; $display("FAIL reset_empty got=%b exp=0", Frl_Empty); end
    if (Frl_Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", Frl_Overflow); end
    if (Frl_RdPhyAddr !== 6'd32) begin errors++; $display("FAIL reset_rd got=%0d exp=32", Frl_RdPhyAddr); end
    if (Frl_HeadPtr !== 5'd0) begin errors++; $display("FAIL reset_head got=%0d exp=0", Frl_HeadPtr); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (Frl_RdPhyAddr !== PR_W'(BASE + i)) begin
        errors++; $display("FAIL drain_rd[%0d] got=%0d exp=%0d", i, Frl_RdPhyAddr, BASE + i);
      end
      cycle(1, 0, 0, 0, 0, 0);
    end
    checks += 3;
    if (Frl_Empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", Frl_Empty); end
    if (Frl_Count !== 5'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", Frl_Count); end
    if (Frl_HeadPtr !== 5'd16) begin errors++; $display("FAIL drain_head got=%0d exp=16", Frl_HeadPtr); end
  endtask

  task automatic test_pop_empty();
    logic [PR_W-1:0] rd0;
    rd0 = Frl_RdPhyAddr;
    cycle(1, 0, 0, 0, 0, 0);
    checks += 4;
    if (Frl_HeadPtr !== 5'd16) begin errors++; $display("FAIL popempty_head got=%0d exp=16", Frl_HeadPtr); end
    if (Frl_RdPhyAddr !== rd0) begin errors++; $display("FAIL popempty_rd got=%0d exp=%0d", Frl_RdPhyAddr, rd0); end
    if (Frl_Overflow !== 1'b0) begin errors++; $display("FAIL popempty_ovf got=%b exp=0", Frl_Overflow); end
    if (Frl_Empty !== 1'b1) begin errors++; $display("FAIL popempty_empty got=%b exp=1", Frl_Empty); end
  endtask

  task automatic test_push_empty();
    Rob_Commit = 1; Rob_CommitRegWrite = 1; Rob_CommitPrePhyAddr = 6'd5;
    #1;
    checks++;
    if (Frl_Empty !== 1'b1) begin errors++; $display("FAIL pushempty_same_cycle got=%b exp=1", Frl_Empty); end
    cycle(0, 1, 1, 5, 0, 0);
    checks += 3;
    if (Frl_Empty !== 1'b0) begin errors++; $display("FAIL pushempty_empty got=%b exp=0", Frl_Empty); end
    if (Frl_RdPhyAddr !== 6'd5) begin errors++; $display("FAIL pushempty_rd got=%0d exp=5", Frl_RdPhyAddr); end
    if (Frl_Count !== 5'd1) begin errors++; $display("FAIL pushempty_count got=%0d exp=1", Frl_Count); end
  endtask

  task automatic test_flush();
    do_reset();
    repeat (3) cycle(1, 0, 0, 0, 0, 0);
    checks++;
    if (Frl_HeadPtr !== 5'd3) begin errors++; $display("FAIL flush_pre_head got=%0d exp=3", Frl_HeadPtr); end
    cycle(1, 0, 0, 0, 1, 1);
    checks += 3;
    if (Frl_HeadPtr !== 5'd1) begin errors++; $display("FAIL flush_head got=%0d exp=1", Frl_HeadPtr); end
    if (Frl_RdPhyAddr !== 6'd33) begin errors++; $display("FAIL flush_rd got=%0d exp=33", Frl_RdPhyAddr); end
    if (Frl_Count !== 5'd15) begin errors++; $display("FAIL flush_count got=%0d exp=15", Frl_Count); end
  endtask

  task automatic test_overflow();
    do_reset();
    cycle(1, 1, 1, 9, 0, 0);
    checks += 3;
    if (Frl_HeadPtr !== 5'd1) begin errors++; $display("FAIL ovf_head got=%0d exp=1", Frl_HeadPtr); end
    if (Frl_Overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", Frl_Overflow); end
    if (Frl_Count !== 5'd15) begin errors++; $display("FAIL ovf_count got=%0d exp=15", Frl_Count); end
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (Frl_Overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", Frl_Overflow); end
  endtask

  task automatic test_wrap();
    int exp_q [$];
    int pushed;
    do_reset();
    repeat (DEPTH) cycle(1, 0, 0, 0, 0, 0);
    pushed = 0;
    for (int k = 0; k < 40; k++) begin
      bit pop, psh;
      pop = (exp_q.size() > 0) && ($urandom_range(1, 0) == 1);
      psh = (pushed < 16) && (exp_q.size() < DEPTH);
      if (pop) begin
        checks++;
        if (Frl_RdPhyAddr !== PR_W'(exp_q[0])) begin
          errors++; $display("FAIL wrap_order got=%0d exp=%0d", Frl_RdPhyAddr, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      cycle(pop, psh, psh, 40 + pushed, 0, 0);
      if (psh) begin exp_q.push_back(40 + pushed); pushed++; end
      checks += 2;
      if (Frl_Count !== PTR_W'(exp_q.size())) begin
        errors++; $display("FAIL wrap_count got=%0d exp=%0d", Frl_Count, exp_q.size());
      end
      if (Frl_HeadPtr !== PTR_W'(m_head % 32)) begin
        errors++; $display("FAIL wrap_head got=%0d exp=%0d", Frl_HeadPtr, m_head % 32);
      end
    end
    while (exp_q.size() > 0) begin
      checks++;
      if (Frl_RdPhyAddr !== PR_W'(exp_q[0])) begin
        errors++; $display("FAIL wrap_drain got=%0d exp=%0d", Frl_RdPhyAddr, exp_q[0]);
      end
      void'(exp_q.pop_front());
      cycle(1, 0, 0, 0, 0, 0);
    end
    checks++;
    if (Frl_HeadPtr !== 5'd0) begin errors++; $display("FAIL wrap_final_head got=%0d exp=0", Frl_HeadPtr); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit pop, cm, rw, fl;
      int tag, cfc, tnext, back_max, back;
      pop = $urandom_range(1, 0) == 1;
      cm  = $urandom_range(3, 0) != 0;
      rw  = $urandom_range(3, 0) != 0;
      tag = $urandom_range(63, 0);
      fl  = $urandom_range(11, 0) == 0;
      tnext = m_tail + ((cm && rw && m_count() < DEPTH) ? 1 : 0);
      back_max = DEPTH - (tnext - m_head);
      if (back_max > m_head) back_max = m_head;
      back = $urandom_range(back_max, 0);
      cfc = (m_head - back) % 32;
      cycle(pop, cm, rw, tag, fl, cfc);
      checks += 4;
      if (Frl_Count !== PTR_W'(m_count())) begin
        errors++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, Frl_Count, m_count());
      end
      if (Frl_Empty !== (m_count() == 0)) begin
        errors++; $display("FAIL rnd_empty n=%0d got=%b exp=%b", n, Frl_Empty, m_count() == 0);
      end
      if (Frl_HeadPtr !== PTR_W'(m_head % 32)) begin
        errors++; $display("FAIL rnd_head n=%0d got=%0d exp=%0d", n, Frl_HeadPtr, m_head % 32);
      end
      if (Frl_Overflow !== m_ovf) begin
        errors++; $display("FAIL rnd_ovf n=%0d got=%b exp=%b", n, Frl_Overflow, m_ovf);
      end
      if (m_count() > 0) begin
        checks++;
        if (Frl_RdPhyAddr !== PR_W'(m_ent[m_head])) begin
          errors++; $display("FAIL rnd_rd n=%0d got=%0d exp=%0d", n, Frl_RdPhyAddr, m_ent[m_head]);
        end
      end
      // Occasional asynchronous reset in the middle of traffic.
      if ($urandom_range(299, 0) == 0) begin
        do_reset();
        checks += 2;
        if (Frl_Count !== 5'd16) begin errors++; $display("FAIL rnd_reset_count got=%0d exp=16", Frl_Count); end
        if (Frl_RdPhyAddr !== 6'd32) begin errors++; $display("FAIL rnd_reset_rd got=%0d exp=32", Frl_RdPhyAddr); end
      end
    end
  endtask

  initial begin
    @(posedge Clk);
    #1;
    test_reset();
    test_drain();
    test_pop_empty();
    test_push_empty();
    test_flush();
    test_overflow();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
